rapid_dcache: RTL

- Responder end of the load/store cache protocol: services CACHE_READ/CACHE_WRITE requests of size BYTE/HALF_WORD/WORD (or CACHE_NOP) from the pipeline's memory stage.
- Direct-mapped, one 32-bit word per line, write-through, no write-allocate.
- Sits between the memory stage and the backing memory port.
- Blocking: one request is outstanding at a time.

---
 rtl/rapid_dcache.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rapid_dcache.sv
// rapid_dcache: blocking, direct-mapped, write-through / no-write-allocate data cache
// with one 32-bit word per line, sitting between the memory stage and backing memory.
package rapid_dcache_pkg;
    localparam int WORD_WIDTH = 4;

    typedef enum logic [1:0] {
        CACHE_NOP = 2'd0,
        BYTE      = 2'd1,
        HALF_WORD = 2'd2,
        WORD      = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE,
        RESPOND
    } state_e;
endpackage

module rapid_dcache
    import rapid_dcache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_op,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = 32 - INDEX_BITS - 2;
    localparam int DATA_BITS  = 8 * WORD_WIDTH;

    state_e state, state_nxt;

    logic                  r_rw;
    op_e                   r_op;
    logic                  r_unsigned;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [DATA_BITS-1:0]  word_q;
    logic [LINES-1:0]      valid_q;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_BITS-1:0]  data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  misalign;
    logic                  bypass;
    logic                  accept;
    logic [3:0]            strb;
    logic [31:0]           shifted_wdata;
    logic [DATA_BITS-1:0]  merged;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [31:0]           load_data;

    assign idx      = r_addr[INDEX_BITS+1:2];
    assign tag      = r_addr[31:INDEX_BITS+2];
    assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
    assign misalign = ((r_op == HALF_WORD) && r_addr[0]) ||
                      ((r_op == WORD) && (r_addr[1:0] != 2'b00));
    assign bypass   = (r_op == CACHE_NOP) || misalign;
    assign accept   = req_valid && req_ready;

    assign shifted_wdata = r_wdata << {r_addr[1:0], 3'b000};
    assign lane_byte     = word_q[{r_addr[1:0], 3'b000} +: 8];
    assign lane_half     = word_q[{r_addr[1], 4'b0000} +: 16];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        strb = 4'b0000;
        case (r_op)
            BYTE:      strb = 4'b0001 << r_addr[1:0];
            HALF_WORD: strb = 4'b0011 << r_addr[1:0];
            WORD:      strb = 4'b1111;
            default:   strb = 4'b0000;
        endcase
    end

    // Store-hit merge: only the strobed lanes take the new data.
    always_comb begin
        merged = data_mem[idx];
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (strb[i]) merged[8*i +: 8] = shifted_wdata[8*i +: 8];
        end
    end

    always_comb begin
        load_data = 32'h0;
        case (r_op)
            BYTE:      load_data = r_unsigned ? {24'h0, lane_byte}
                                              : {{24{lane_byte[7]}}, lane_byte};
            HALF_WORD: load_data = r_unsigned ? {16'h0, lane_half}
                                              : {{16{lane_half[15]}}, lane_half};
            WORD:      load_data = word_q;
            default:   load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOOKUP;
            LOOKUP: begin
                if (bypass)     state_nxt = RESPOND;
                else if (r_rw)  state_nxt = WRITE;
                else if (hit)   state_nxt = RESPOND;
                else            state_nxt = REFILL;
            end
            REFILL:  if (mem_ready) state_nxt = RESPOND;
            WRITE:   if (mem_ready) state_nxt = RESPOND;
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            r_rw       <= 1'b0;
            r_op       <= CACHE_NOP;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            word_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_rw       <= req_rw;
                r_op       <= op_e'(req_op);
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            if (state == LOOKUP && !bypass && !r_rw && hit) word_q <= data_mem[idx];
            if (state == REFILL && mem_ready) begin
                valid_q[idx] <= 1'b1;
                word_q       <= mem_rdata;
            end
        end
    end

    // NOTE: tag/data arrays have no reset; cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ready) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata;
        end else if (state == LOOKUP && !bypass && r_rw && hit) begin
            data_mem[idx] <= merged;
        end
    end

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESPOND);
    assign resp_error = (state == RESPOND) && misalign;
    assign resp_rdata = ((state == RESPOND) && !r_rw && !misalign) ? load_data : 32'h0;

    assign mem_req   = (state == REFILL) || (state == WRITE);
    assign mem_we    = (state == WRITE);
    assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata = (state == WRITE) ? shifted_wdata : 32'h0;
    assign mem_wstrb = (state == WRITE) ? strb : 4'b0000;
endmodule
